// File: rtl/vga_bw_pkg.sv
// Shared constants and fetch FSM encoding for the white/black VGA pipeline
// (timing generator, pixel fetch, output core).
package vga_bw_pkg;

  localparam int H_ACTIVE        = 640;
  localparam int V_ACTIVE        = 480;
  localparam int WORD_W          = 16;
  localparam int WORDS_PER_FRAME = H_ACTIVE * V_ACTIVE / WORD_W;
  localparam int ADDR_W          = 15;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_bw_word_fifo.sv
// Two-entry synchronous word FIFO with flush. Push and pop may happen in
// the same cycle; a push into a full FIFO is accepted only alongside a pop.
module vga_bw_word_fifo
  import vga_bw_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != 2'd0);
  assign do_push  = push && ((count != 2'd2) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: contents are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_bw_pixel_fetch.sv
// 1 bpp framebuffer reader: prefetches words over req/ack into a 2-entry
// buffer and shifts them out MSB-first, one pixel per display-enabled cycle.
module vga_bw_pixel_fetch #(
  parameter int H_ACTIVE = vga_bw_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_bw_pkg::V_ACTIVE,
  parameter int WORD_W   = vga_bw_pkg::WORD_W,
  parameter int ADDR_W   = vga_bw_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic                     de,
  output logic                     pixel,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [WORD_W-1:0]        mem_rdata,
  output logic                     underflow,
  output vga_bw_pkg::fetch_state_t fetch_state
);
  import vga_bw_pkg::*;

  localparam int              WORDS    = H_ACTIVE * V_ACTIVE / WORD_W;
  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [ADDR_W:0] WORDS_L  = (ADDR_W+1)'(WORDS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W:0]   fetched;
  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_rdata;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;

  assign fetch_state = state;
  assign fifo_empty  = (fifo_count == 2'd0);
  assign fifo_pop    = de && !frame_start && (bit_cnt == '0) && !fifo_empty;

  vga_bw_word_fifo #(.WIDTH(WORD_W)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_rdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state;
    fifo_push  = 1'b0;
    case (state)
      FETCH_IDLE: begin
        if ((fifo_count != 2'd2) && (fetched < WORDS_L)) state_next = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (mem_ack) begin
          state_next = FETCH_IDLE;
          fifo_push  = 1'b1;
        end
      end
      FETCH_DRAIN: begin
        if (mem_ack) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase
    // A new frame restarts fetching; an unfinished handshake is completed
    // in DRAIN and its data thrown away.
    if (frame_start) begin
      fifo_push  = 1'b0;
      state_next = ((state != FETCH_IDLE) && !mem_ack) ? FETCH_DRAIN : FETCH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= FETCH_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      fetched  <= '0;
    end else begin
      state   <= state_next;
      mem_req <= (state_next != FETCH_IDLE);
      if ((state == FETCH_IDLE) && (state_next == FETCH_REQ)) mem_addr <= fetched[ADDR_W-1:0];
      if (frame_start)    fetched <= '0;
      else if (fifo_push) fetched <= fetched + (ADDR_W+1)'(1);
    end
  end

  // An empty buffer at a word boundary yields a black word so later words
  // stay aligned to their screen positions.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel     <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      underflow <= 1'b0;
    end else if (frame_start) begin
      pixel     <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      underflow <= 1'b0;
    end else if (de) begin
      if (bit_cnt == '0) begin
        bit_cnt <= CNT_W'(1);
        if (!fifo_empty) begin
          pixel <= fifo_rdata[WORD_W-1];
          shreg <= {fifo_rdata[WORD_W-2:0], 1'b0};
        end else begin
          pixel     <= 1'b0;
          shreg     <= '0;
          underflow <= 1'b1;
        end
      end else begin
        pixel   <= shreg[WORD_W-1];
        shreg   <= {shreg[WORD_W-2:0], 1'b0};
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CNT_W'(1);
      end
    end else begin
      pixel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_bw_pixel_fetch.sv
// Bench for vga_bw_pixel_fetch on a reduced 64x16 frame (64 words), with a
// req/ack memory responder and a queue-based pixel/fetch model.
module tb_vga_bw_pixel_fetch;
  import vga_bw_pkg::*;

  localparam int TB_H     = 64;
  localparam int TB_V     = 16;
  localparam int TB_W     = 16;
  localparam int TB_AW    = 15;
  localparam int TB_WORDS = TB_H * TB_V / TB_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              frame_start = 1'b0;
  logic              de = 1'b0;
  logic              mem_ack = 1'b0;
  logic [TB_W-1:0]   mem_rdata = '0;
  logic              pixel;
  logic              mem_req;
  logic [TB_AW-1:0]  mem_addr;
  logic              underflow;
  fetch_state_t      fetch_state;

  vga_bw_pixel_fetch #(
    .H_ACTIVE (TB_H),
    .V_ACTIVE (TB_V),
    .WORD_W   (TB_W),
    .ADDR_W   (TB_AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .de          (de),
    .pixel       (pixel),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .underflow   (underflow),
    .fetch_state (fetch_state)
  );

  // ---------------- clock ----------------
  always #20 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [TB_W-1:0] mem_data [TB_WORDS];
  int ack_lat = 1;
  int cur_lat = 1;
  int req_cyc = 0;
  bit rand_lat = 1'b0;

  always @(posedge clk) begin
    #2;
    mem_ack   = 1'b0;
    mem_rdata = TB_W'($urandom);
    if (reset_n && mem_req) begin
      if (req_cyc == 0) cur_lat = rand_lat ? int'($urandom_range(1, 12)) : ack_lat;
      req_cyc++;
      if (req_cyc >= cur_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_data[int'(mem_addr) % TB_WORDS];
        req_cyc   = 0;
      end
    end else begin
      req_cyc = 0;
    end
  end

  // ---------------- behavioural model / scoreboard ----------------
  logic [TB_W-1:0] exp_q[$];
  logic            bit_q[$];
  logic            exp_pixel = 1'b0;
  logic            exp_uf = 1'b0;
  int              exp_addr = 0;
  bit              discard = 1'b0;
  bit              just_reset = 1'b0;
  bit              model_ok = 1'b0;
  bit              prev_req = 1'b0;
  logic [TB_AW-1:0] prev_addr = '0;
  int              ones_cnt = 0;

  task automatic model_step();
    logic [TB_W-1:0] w;
    if (!reset_n) begin
      exp_q.delete();
      bit_q.delete();
      exp_pixel  = 1'b0;
      exp_uf     = 1'b0;
      exp_addr   = 0;
      discard    = 1'b0;
      just_reset = 1'b1;
      model_ok   = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (frame_start) begin
        exp_q.delete();
        bit_q.delete();
        exp_pixel = 1'b0;
        exp_uf    = 1'b0;
        exp_addr  = 0;
        discard   = mem_req && !mem_ack;
      end else begin
        if (de) begin
          if (bit_q.size() == 0) begin
            if (exp_q.size() != 0) w = exp_q.pop_front();
            else begin
              w      = '0;
              exp_uf = 1'b1;
            end
            for (int b = TB_W - 1; b >= 0; b--) bit_q.push_back(w[b]);
          end
          exp_pixel = bit_q.pop_front();
        end else begin
          exp_pixel = 1'b0;
        end
        if (mem_ack) begin
          if (discard) discard = 1'b0;
          else begin
            exp_q.push_back(mem_rdata);
            exp_addr++;
            chk("buffer_depth_ok", 32'(exp_q.size() <= 2), 1);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      chk("pixel", pixel, exp_pixel);
      chk("underflow", underflow, exp_uf);
      if (just_reset) begin
        chk("req_after_reset", mem_req, 0);
        chk("addr_after_reset", mem_addr, 0);
      end else if (!discard) begin
        if (exp_addr >= TB_WORDS) chk("req_after_last_word", mem_req, 0);
        else if (mem_req) chk("req_addr", mem_addr, exp_addr);
      end
      if (prev_req && mem_req) chk("addr_stable", mem_addr, prev_addr);
    end
    if (pixel === 1'b1) ones_cnt++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic d, input logic fs);
    @(posedge clk);
    #1;
    de          = d;
    frame_start = fs;
  endtask

  task automatic start_frame(input int idle);
    cycle(1'b0, 1'b1);
    repeat (idle) cycle(1'b0, 1'b0);
  endtask

  task automatic apply_reset(input logic d);
    @(posedge clk);
    #1;
    reset_n     = 1'b0;
    de          = d;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    de      = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_pixel", pixel, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_state", 32'(fetch_state), 32'(FETCH_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  n;
    bit  found;
    logic [TB_AW-1:0] addr_at;

    for (int k = 0; k < TB_WORDS; k++) mem_data[k] = TB_W'(k);
    repeat (2) @(posedge clk);
    apply_reset(1'b0);

    // Word k = k, 1-cycle ack, 640 pixels = words 0..39 (100 ones in total).
    ack_lat = 1;
    start_frame(20);
    ones_cnt = 0;
    repeat (640) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    chk("t1_ones_words_0_39", ones_cnt, 100);
    chk("t1_no_underflow", underflow, 0);

    // Full frame at 14-cycle ack latency, random contents.
    for (int k = 0; k < TB_WORDS; k++) mem_data[k] = TB_W'($urandom);
    ack_lat = 14;
    start_frame(40);
    repeat (TB_WORDS * TB_W) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    chk("t2_fetch_count", exp_addr, TB_WORDS);
    chk("t2_no_underflow", underflow, 0);
    repeat (40) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);
    chk("t2_underflow_past_frame", underflow, 1);
    chk("t2_no_extra_fetch", exp_addr, TB_WORDS);

    // 20-cycle ack latency starves the serialiser.
    ack_lat = 20;
    start_frame(60);
    repeat (400) cycle(1'b1, 1'b0);
    chk("t3_underflow", underflow, 1);

    // Reset in the middle of a line, then first pixel of a new frame.
    apply_reset(1'b1);
    mem_data[0] = 16'h8000;
    ack_lat = 1;
    start_frame(10);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("t5_first_pixel", pixel, 1);

    // frame_start during a request: the ack 3 cycles later is discarded.
    start_frame(10);
    repeat (100) cycle(1'b1, 1'b0);
    ack_lat = 4;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(1'b1, 1'b0);
      if (mem_req && req_cyc == 0) found = 1'b1;
    end
    chk("t4_req_seen", 32'(found), 1);
    if (found) begin
      frame_start = 1'b1;
      addr_at = mem_addr;
      chk("t4_addr_nonzero", 32'(addr_at != 0), 1);
      for (n = 1; n <= 20; n++) begin
        cycle(1'b0, 1'b0);
        #2;
        if (mem_ack) break;
      end
      chk("t4_drain_ack_delay", n, 3);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
        cycle(1'b0, 1'b0);
        if (mem_req) found = 1'b1;
      end
      chk("t4_restart_seen", 32'(found), 1);
      chk("t4_restart_addr", mem_addr, 0);
    end

    // de toggled every cycle.
    ack_lat = 3;
    start_frame(20);
    for (int i = 0; i < 320; i++) cycle(logic'(i % 2 == 0), 1'b0);

    // Random de, random ack latency, a frame_start mid-stream.
    rand_lat = 1'b1;
    start_frame(20);
    for (int i = 0; i < 600; i++) cycle(logic'($urandom_range(0, 3) != 0), logic'(i == 300));
    rand_lat = 1'b0;
    repeat (4) cycle(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
